// File: rtl/iobuf_ctrl_pkg.sv
// Shared definitions for the pad-bus turnaround controller: state encoding and counter widths.
package iobuf_ctrl_pkg;

    localparam int unsigned TA_W    = 4;
    localparam int unsigned BURST_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TON  = 2'd1,
        S_DRV  = 2'd2,
        S_TOFF = 2'd3
    } state_t;

endpackage

// File: rtl/iobuf_turnaround_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; i_rr_ptr names the requester preferred on a tie.
module rr_arb2
(
    input  logic [1:0] i_req,
    input  logic       i_rr_ptr,
    output logic [1:0] o_win_c
);

    always_comb begin
        o_win_c = 2'b00;
        if (i_req == 2'b11) begin
            o_win_c = i_rr_ptr ? 2'b10 : 2'b01;
        end else begin
            o_win_c = i_req;
        end
    end

endmodule

// File: rtl/iobuf_turnaround_ctrl.sv
// Half-duplex pad bus sequencer: arbitrates two drivers, inserts turnaround dead cycles
// around every drive, and captures receive data while the bus is released.
module iobuf_turnaround_ctrl
    import iobuf_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned TA_CYCLES = 2,
    parameter int unsigned MAX_BURST = 16
)
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_req,
    input  logic [WIDTH-1:0] i_data0,
    input  logic [WIDTH-1:0] i_data1,
    output logic [1:0]       o_gnt,
    output logic [WIDTH-1:0] o_pad_i,
    output logic             o_pad_t,
    input  logic [WIDTH-1:0] i_pad_o,
    input  logic             i_rx_en,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rx_valid,
    output logic             o_busy
);

    localparam logic [TA_W-1:0]    TA_LOAD    = TA_W'(TA_CYCLES - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    state_t               r_state;
    logic                 r_owner;
    logic                 r_rr_ptr;
    logic [TA_W-1:0]      r_ta_cnt;
    logic [BURST_W-1:0]   r_burst;
    logic [1:0]           r_gnt;
    logic [WIDTH-1:0]     r_pad_i;
    logic                 r_pad_t;
    logic [WIDTH-1:0]     r_rx_data;
    logic                 r_rx_valid;
    logic                 r_busy;

    state_t               w_state_nxt;
    logic                 w_owner_nxt;
    logic                 w_rr_nxt;
    logic [TA_W-1:0]      w_ta_nxt;
    logic [BURST_W-1:0]   w_burst_nxt;
    logic                 w_cap;
    logic                 w_drv_nxt;
    logic [1:0]           w_win;

    rr_arb2 u_arb (
        .i_req    (i_req),
        .i_rr_ptr (r_rr_ptr),
        .o_win_c  (w_win)
    );

    // Next-state and counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        w_ta_nxt    = r_ta_cnt;
        w_burst_nxt = r_burst;
        w_cap       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|i_req) begin
                    w_state_nxt = S_TON;
                    w_owner_nxt = w_win[1] & ~w_win[0];
                    w_ta_nxt    = TA_LOAD;
                end else begin
                    w_cap = i_rx_en;
                end
            end
            S_TON: begin
                if (r_ta_cnt == '0) begin
                    w_state_nxt = S_DRV;
                    w_burst_nxt = '0;
                end else begin
                    w_ta_nxt = r_ta_cnt - TA_W'(1);
                end
            end
            S_DRV: begin
                w_burst_nxt = r_burst + BURST_W'(1);
                if (!i_req[r_owner] || (r_burst == BURST_LAST)) begin
                    w_state_nxt = S_TOFF;
                    w_ta_nxt    = TA_LOAD;
                    w_rr_nxt    = ~r_owner;
                end
            end
            S_TOFF: begin
                if (r_ta_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_ta_nxt = r_ta_cnt - TA_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_drv_nxt = (w_state_nxt == S_DRV);

    // Outputs are registered from the next state so they line up with the state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_owner    <= 1'b0;
            r_rr_ptr   <= 1'b0;
            r_ta_cnt   <= '0;
            r_burst    <= '0;
            r_gnt      <= 2'b00;
            r_pad_i    <= '0;
            r_pad_t    <= 1'b1;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_ta_cnt   <= w_ta_nxt;
            r_burst    <= w_burst_nxt;
            r_pad_t    <= ~w_drv_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_rx_valid <= w_cap;
            if (w_drv_nxt) begin
                r_gnt   <= w_owner_nxt ? 2'b10 : 2'b01;
                r_pad_i <= w_owner_nxt ? i_data1 : i_data0;
            end else begin
                r_gnt   <= 2'b00;
            end
            if (w_cap) begin
                r_rx_data <= i_pad_o;
            end
        end
    end

    assign o_gnt      = r_gnt;
    assign o_pad_i    = r_pad_i;
    assign o_pad_t    = r_pad_t;
    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_iobuf_turnaround_ctrl.sv
// Scoreboard bench for iobuf_turnaround_ctrl: directed scenarios followed by random traffic,
// checked against a phase-level reference model.
module tb_iobuf_turnaround_ctrl;

    localparam int TA   = 2;
    localparam int MAXB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = 2'b11;
    logic [7:0] d0 = 8'h00;
    logic [7:0] d1 = 8'h00;
    logic       rx_en = 1'b0;
    logic [7:0] pad_o = 8'h00;

    logic [1:0] o_gnt;
    logic [7:0] o_pad_i;
    logic       o_pad_t;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       o_busy;

    iobuf_turnaround_ctrl #(.WIDTH(8), .TA_CYCLES(TA), .MAX_BURST(MAXB)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_data0    (d0),
        .i_data1    (d1),
        .o_gnt      (o_gnt),
        .o_pad_i    (o_pad_i),
        .o_pad_t    (o_pad_t),
        .i_pad_o    (pad_o),
        .i_rx_en    (rx_en),
        .o_rx_data  (o_rx_data),
        .o_rx_valid (o_rx_valid),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pad_t;
        logic       busy;
        logic [1:0] gnt;
        logic       rx_valid;
        logic [7:0] rx_data;
        logic       chk_pad_i;
        logic [7:0] pad_i;
    } cyc_t;

    typedef struct {
        logic [1:0] gnt;
        logic [7:0] data;
    } drv_t;

    cyc_t cq[$];
    drv_t dq[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: bus phases with remaining-cycle and talk-cycle counts
    typedef enum {LISTEN, PRE_GAP, TALK, POST_GAP} phase_t;
    phase_t     m_phase = LISTEN;
    int         m_left = 0;
    int         m_owner = 0;
    int         m_pref = 0;
    int         m_talked = 0;
    logic [7:0] m_rx_data = 8'h00;

    task automatic model_edge();
        cyc_t c;
        drv_t d;
        bit   talk;
        bit   rxv;
        talk = 1'b0;
        rxv  = 1'b0;
        c.chk_pad_i = 1'b0;
        c.pad_i     = 8'h00;
        if (!rst_n) begin
            m_phase   = LISTEN;
            m_pref    = 0;
            m_rx_data = 8'h00;
            c.chk_pad_i = 1'b1;
        end else begin
            case (m_phase)
                LISTEN: begin
                    if (req != 2'b00) begin
                        m_owner = (req == 2'b11) ? m_pref : (req[1] ? 1 : 0);
                        m_phase = PRE_GAP;
                        m_left  = TA;
                    end else if (rx_en) begin
                        m_rx_data = pad_o;
                        rxv = 1'b1;
                    end
                end
                PRE_GAP: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase  = TALK;
                        m_talked = 0;
                        talk     = 1'b1;
                    end
                end
                TALK: begin
                    m_talked++;
                    if (!req[m_owner] || m_talked == MAXB) begin
                        m_phase = POST_GAP;
                        m_left  = TA;
                        m_pref  = 1 - m_owner;
                    end else begin
                        talk = 1'b1;
                    end
                end
                POST_GAP: begin
                    m_left--;
                    if (m_left == 0) m_phase = LISTEN;
                end
            endcase
        end
        c.pad_t    = !talk;
        c.gnt      = talk ? 2'(1 << m_owner) : 2'b00;
        c.busy     = rst_n && (m_phase != LISTEN);
        c.rx_valid = rxv;
        c.rx_data  = m_rx_data;
        cq.push_back(c);
        if (talk) begin
            d.gnt  = 2'(1 << m_owner);
            d.data = (m_owner == 1) ? d1 : d0;
            dq.push_back(d);
        end
    endtask

    // Model consumes the inputs the DUT sees at this edge, then new inputs are applied
    task automatic step(input logic rn, input logic [1:0] rq, input logic [7:0] a,
                        input logic [7:0] b, input logic re, input logic [7:0] po);
        @(posedge clk);
        model_edge();
        #1;
        rst_n = rn;
        req   = rq;
        d0    = a;
        d1    = b;
        rx_en = re;
        pad_o = po;
    endtask

    // Monitor: per-cycle expectations, plus drive words popped whenever a grant is shown
    always @(negedge clk) begin
        cyc_t c;
        drv_t d;
        if (cq.size() > 0) begin
            c = cq.pop_front();
            check("pad_t",    32'(o_pad_t),    32'(c.pad_t));
            check("busy",     32'(o_busy),     32'(c.busy));
            check("gnt",      32'(o_gnt),      32'(c.gnt));
            check("rx_valid", 32'(o_rx_valid), 32'(c.rx_valid));
            check("rx_data",  32'(o_rx_data),  32'(c.rx_data));
            if (c.chk_pad_i) check("pad_i_reset", 32'(o_pad_i), 32'h0);
        end
        if (o_gnt != 2'b00) begin
            if (dq.size() == 0) begin
                check("drive_expected", 32'(o_gnt), 32'h0);
            end else begin
                d = dq.pop_front();
                check("drive_gnt",  32'(o_gnt),   32'(d.gnt));
                check("drive_data", 32'(o_pad_i), 32'(d.data));
            end
        end
    end

    initial begin
        logic [1:0] cur_req;
        // Reset held with both requesting, then first grant (requester 0) lasting one cycle
        for (int i = 0; i < 3; i++) step(1'b0, 2'b11, 8'h00, 8'h00, 1'b0, 8'h00);
        step(1'b1, 2'b11, 8'h11, 8'h22, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00);
        // Single burst of five drive cycles carrying A5..A9
        for (int i = 0; i < 7; i++) step(1'b1, 2'b01, 8'(8'hA3 + i), 8'h5A, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00);
        // Contention: alternating full-length bursts
        for (int i = 0; i < 70; i++) step(1'b1, 2'b11, 8'($urandom), 8'($urandom), 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) step(1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00);
        // Receive while idle, then while a drive is in progress
        for (int i = 0; i < 4; i++) step(1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 8'h3C);
        for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 8'h77, 8'h00, 1'b1, 8'hC3);
        for (int i = 0; i < 6; i++) step(1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00);
        // Reset lands in the third drive cycle
        for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 8'(8'h40 + i), 8'h00, 1'b0, 8'h00);
        step(1'b0, 2'b01, 8'h00, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00);
        // One-cycle request pulse from requester 1
        step(1'b1, 2'b10, 8'h00, 8'hE1, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b1, 2'b00, 8'h00, 8'hE2, 1'b0, 8'h00);
        // Random traffic with held requests and rare resets
        cur_req = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) cur_req = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 299) != 0), cur_req, 8'($urandom), 8'($urandom),
                 1'($urandom), 8'($urandom));
        end
        for (int i = 0; i < 2 * TA + MAXB; i++) step(1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check("drive_queue_drained", 32'(dq.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
